// File: rtl/uart_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter_if
// Description : Byte handshake between host logic and the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_transmitter_if;
    logic [7:0] transmit_data;
    logic       transmit_valid;
    logic       transmit_ready;

    modport master (
        output transmit_data,
        output transmit_valid,
        input  transmit_ready
    );

    modport slave (
        input  transmit_data,
        input  transmit_valid,
        output transmit_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : 8N1/8N2 UART transmitter with a small byte FIFO, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
    parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
    parameter int unsigned BAUD_RATE       = 9600,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned STOP_BITS       = 1
) (
    input  wire logic          clock,
    input  wire logic          reset,
    uart_transmitter_if.slave  tx_if,
    output logic               transmit_uart,
    output logic               busy
);

    localparam int unsigned CLOCKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int unsigned CW             = $clog2(CLOCKS_PER_BIT * STOP_BITS) + 1;
    localparam int unsigned AW             = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LOAD = CW'(CLOCKS_PER_BIT * STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Byte FIFO; pointers carry one extra wrap bit to tell full from empty
    // ------------------------------------------------------------------
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_head;

    state_t      state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        line_q;

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign w_push  = tx_if.transmit_valid && !w_full;
    assign w_head  = mem_q[rd_ptr_q[AW-1:0]];

    assign tx_if.transmit_ready = !w_full;

    // The FSM takes a byte when idle, or at the last stop-bit cycle for gapless frames.
    assign w_pop = !w_empty &&
                   ((state_q == IDLE) || ((state_q == STOP) && (baud_q == '0)));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= tx_if.transmit_data;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer; the line is registered and set one state ahead
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            line_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    line_q <= 1'b1;
                    if (w_pop) begin
                        shift_q <= w_head;
                        baud_q  <= BIT_LOAD;
                        line_q  <= 1'b0;
                        state_q <= START;
                    end
                end

                START: begin
                    if (baud_q == '0) begin
                        baud_q    <= BIT_LOAD;
                        bit_idx_q <= '0;
                        line_q    <= shift_q[0];
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q - CW'(1);
                    end
                end

                DATA: begin
                    if (baud_q == '0) begin
                        if (bit_idx_q == 3'd7) begin
                            baud_q  <= STOP_LOAD;
                            line_q  <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            baud_q    <= BIT_LOAD;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                            line_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - CW'(1);
                    end
                end

                STOP: begin
                    if (baud_q == '0) begin
                        if (w_pop) begin
                            shift_q <= w_head;
                            baud_q  <= BIT_LOAD;
                            line_q  <= 1'b0;
                            state_q <= START;
                        end else begin
                            line_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - CW'(1);
                    end
                end

                default: begin
                    line_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign transmit_uart = line_q;
    assign busy          = (state_q != IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_transmitter
// Description : Self-checking bench for uart_transmitter (1 and 2 stop bits).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_transmitter;

    localparam int CF    = 100;
    localparam int BR    = 10;
    localparam int CPB   = CF / BR;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    uart_transmitter_if if1();
    uart_transmitter_if if2();

    logic line1, busy1, line2, busy2;

    uart_transmitter #(.CLOCK_FREQUENCY(CF), .BAUD_RATE(BR), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut1 (
        .clock(clock), .reset(reset), .tx_if(if1.slave), .transmit_uart(line1), .busy(busy1));

    uart_transmitter #(.CLOCK_FREQUENCY(CF), .BAUD_RATE(BR), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
        .clock(clock), .reset(reset), .tx_if(if2.slave), .transmit_uart(line2), .busy(busy2));

    int tests = 0;
    int fails = 0;

    bit          cap_en = 1'b0;
    logic        s_line1[$], s_busy1[$], s_line2[$], s_busy2[$];
    logic        src[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  dec_q[$];

    always @(negedge clock) begin
        if (cap_en) begin
            s_line1.push_back(line1);
            s_busy1.push_back(busy1);
            s_line2.push_back(line2);
            s_busy2.push_back(busy2);
        end
    end

    // Sample 0 is the cycle after the accepting edge; frames follow back to back.
    function automatic logic model_line(input int t, input int stop);
        int flen;
        int f;
        int b;
        flen = CPB * (9 + stop);
        if (t < 1) return 1'b1;
        t = t - 1;
        f = t / flen;
        if (f >= exp_q.size()) return 1'b1;
        b = (t % flen) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return exp_q[f][b-1];
        return 1'b1;
    endfunction

    function automatic logic model_busy(input int t, input int stop);
        return (t <= exp_q.size() * CPB * (9 + stop));
    endfunction

    task automatic cap_clear();
        s_line1.delete(); s_busy1.delete(); s_line2.delete(); s_busy2.delete();
    endtask

    // Mid-bit sampling receiver over the captured line in src.
    task automatic decode(input int stop);
        int t;
        logic [7:0] b;
        dec_q.delete();
        t = 1;
        while (t + CPB*(8 + stop) + CPB/2 < src.size()) begin
            if (src[t] == 1'b0 && src[t-1] == 1'b1) begin
                for (int i = 0; i < 8; i++) b[i] = src[t + CPB*(i+1) + CPB/2];
                if (src[t + CPB/2] == 1'b0 && src[t + CPB*9 + CPB/2] == 1'b1) dec_q.push_back(b);
                t += CPB*9 + CPB/2;
            end else begin
                t++;
            end
        end
    endtask

    task automatic push(input int sel, input logic [7:0] d);
        int g;
        @(negedge clock);
        g = 0;
        if (sel == 1) begin if1.transmit_data = d; if1.transmit_valid = 1'b1; end
        else          begin if2.transmit_data = d; if2.transmit_valid = 1'b1; end
        while (((sel == 1) ? if1.transmit_ready : if2.transmit_ready) !== 1'b1 && g < 1000) begin
            @(negedge clock); g++;
        end
        if (g >= 1000) begin
            tests++; fails++;
            $display("FAIL push_timeout ready stayed low, required 1");
        end
        @(posedge clock);
        #1;
        if1.transmit_valid = 1'b0;
        if2.transmit_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) begin
            @(negedge clock);
            tests += 4;
            if (line1 !== 1'b1) begin fails++; $display("FAIL reset_line got=%b exp=1", line1); end
            if (if1.transmit_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", if1.transmit_ready); end
            if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy1); end
            if (line2 !== 1'b1) begin fails++; $display("FAIL reset_line2 got=%b exp=1", line2); end
        end
        reset = 1'b0;
    endtask

    task automatic check_frames1(input string name, input int n);
        for (int t = 0; t < n; t++) begin
            tests += 2;
            if (s_line1[t] !== model_line(t, 1)) begin
                fails++; $display("FAIL %s_line t=%0d got=%b exp=%b", name, t, s_line1[t], model_line(t, 1));
            end
            if (s_busy1[t] !== model_busy(t, 1)) begin
                fails++; $display("FAIL %s_busy t=%0d got=%b exp=%b", name, t, s_busy1[t], model_busy(t, 1));
            end
        end
        src = s_line1;
        decode(1);
        tests++;
        if (dec_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL %s_count got=%0d exp=%0d", name, dec_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests++;
                if (dec_q[i] !== exp_q[i]) begin
                    fails++; $display("FAIL %s_byte%0d got=%h exp=%h", name, i, dec_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_single();
        exp_q = '{8'hAA};
        cap_clear();
        push(1, 8'hAA);
        cap_en = 1'b1;
        repeat (104) @(negedge clock);
        #1 cap_en = 1'b0;
        check_frames1("single", 104);
    endtask

    task automatic test_back_to_back();
        int idx;
        int g;
        logic acc;
        exp_q = '{8'h55, 8'h0F, 8'hF0, 8'h81, 8'h3C};
        cap_clear();
        @(negedge clock);
        if1.transmit_data = exp_q[0]; if1.transmit_valid = 1'b1;
        @(posedge clock);
        #1 cap_en = 1'b1;
        idx = 1; g = 0;
        if1.transmit_data = exp_q[1];
        while (idx < 5 && g < 1000) begin
            @(negedge clock);
            acc = if1.transmit_ready;
            @(posedge clock);
            #1;
            if (acc) idx++;
            if (idx < 5) if1.transmit_data = exp_q[idx];
            else         if1.transmit_valid = 1'b0;
            g++;
        end
        if1.transmit_valid = 1'b0;
        tests++;
        if (idx !== 5) begin fails++; $display("FAIL b2b_accept got=%0d exp=5", idx); end
        @(negedge clock);
        tests++;
        if (if1.transmit_ready !== 1'b0) begin fails++; $display("FAIL b2b_full_ready got=%b exp=0", if1.transmit_ready); end
        g = 0;
        while (s_line1.size() < 504 && g < 2000) begin @(negedge clock); g++; end
        #1 cap_en = 1'b0;
        tests++;
        if (g >= 2000) begin fails++; $display("FAIL b2b_timeout samples=%0d exp=504", s_line1.size()); end
        else check_frames1("b2b", 504);
    endtask

    task automatic test_stop2();
        logic [7:0] r;
        int t;
        int low_run;
        int high_run;
        r = 8'($urandom);
        exp_q = '{8'h00, r};
        cap_clear();
        push(2, 8'h00);
        cap_en = 1'b1;
        push(2, r);
        repeat (225) @(negedge clock);
        #1 cap_en = 1'b0;
        for (int i = 0; i < 224; i++) begin
            tests += 2;
            if (s_line2[i] !== model_line(i, 2)) begin
                fails++; $display("FAIL stop2_line t=%0d got=%b exp=%b", i, s_line2[i], model_line(i, 2));
            end
            if (s_busy2[i] !== model_busy(i, 2)) begin
                fails++; $display("FAIL stop2_busy t=%0d got=%b exp=%b", i, s_busy2[i], model_busy(i, 2));
            end
        end
        t = 1; low_run = 0; high_run = 0;
        while (t < s_line2.size() && s_line2[t] === 1'b0) begin low_run++; t++; end
        while (t < s_line2.size() && s_line2[t] === 1'b1) begin high_run++; t++; end
        tests += 2;
        if (low_run !== 90) begin fails++; $display("FAIL stop2_low_run got=%0d exp=90", low_run); end
        if (high_run !== 20 + ((r[0] == 1'b1) ? 0 : 0)) begin fails++; $display("FAIL stop2_high_run got=%0d exp=20", high_run); end
        src = s_line2;
        decode(2);
        tests++;
        if (dec_q.size() !== 2 || dec_q[0] !== 8'h00 || dec_q[1] !== r) begin
            fails++; $display("FAIL stop2_decode got_n=%0d exp_n=2 exp_byte1=%h", dec_q.size(), r);
        end
    endtask

    task automatic check_after_reset(input string name);
        #1;
        tests += 3;
        if (line1 !== 1'b1) begin fails++; $display("FAIL %s_line got=%b exp=1", name, line1); end
        if (if1.transmit_ready !== 1'b1) begin fails++; $display("FAIL %s_ready got=%b exp=1", name, if1.transmit_ready); end
        if (busy1 !== 1'b0) begin fails++; $display("FAIL %s_busy got=%b exp=0", name, busy1); end
    endtask

    task automatic test_reset_midframe();
        int bad;
        exp_q = '{8'($urandom)};
        cap_clear();
        push(1, exp_q[0]);
        cap_en = 1'b1;
        repeat (6) @(negedge clock);
        tests++;
        if (line1 !== model_line(5, 1)) begin fails++; $display("FAIL rst_start_bit got=%b exp=0", line1); end
        #2 reset = 1'b1;
        check_after_reset("rst_in_start");
        cap_en = 1'b0;
        @(negedge clock) reset = 1'b0;

        exp_q = '{8'hFF};
        push(1, 8'hFF);
        push(1, 8'h00);
        repeat (45) @(negedge clock);
        #2 reset = 1'b1;
        check_after_reset("rst_in_data3");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        bad = 0;
        repeat (120) begin
            @(negedge clock);
            if (line1 !== 1'b1 || busy1 !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL rst_fifo_cleared active_cycles=%0d exp=0", bad); end

        exp_q = '{8'($urandom)};
        cap_clear();
        push(1, exp_q[0]);
        cap_en = 1'b1;
        repeat (104) @(negedge clock);
        #1 cap_en = 1'b0;
        check_frames1("post_rst", 104);
    endtask

    task automatic test_random_valid();
        int g;
        int blocked;
        logic [7:0] d;
        exp_q.delete();
        cap_clear();
        blocked = 0;
        cap_en = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            d = 8'($urandom);
            if1.transmit_data  = d;
            if1.transmit_valid = 1'($urandom_range(0, 1));
            if (if1.transmit_valid && if1.transmit_ready) exp_q.push_back(d);
            if (if1.transmit_valid && !if1.transmit_ready) blocked++;
        end
        @(negedge clock);
        if1.transmit_valid = 1'b0;
        g = 0;
        while (busy1 !== 1'b0 && g < 3000) begin @(negedge clock); g++; end
        repeat (5) @(negedge clock);
        #1 cap_en = 1'b0;
        tests++;
        if (g >= 3000) begin fails++; $display("FAIL rand_timeout busy stuck, required 0"); end
        src = s_line1;
        decode(1);
        tests++;
        if (dec_q.size() !== exp_q.size()) begin
            fails++; $display("FAIL rand_frames got=%0d exp=%0d blocked=%0d", dec_q.size(), exp_q.size(), blocked);
        end else begin
            foreach (exp_q[i]) begin
                tests++;
                if (dec_q[i] !== exp_q[i]) begin
                    fails++; $display("FAIL rand_byte%0d got=%h exp=%h", i, dec_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        if1.transmit_data = '0; if1.transmit_valid = 1'b0;
        if2.transmit_data = '0; if2.transmit_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stop2();
        test_reset_midframe();
        test_random_valid();
        test_random_valid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
